qu_res_station: RTL
===================

# qu_res_station

Reservation station for the Qu out-of-order core. It accepts dispatched micro-ops as `res_st_cell_t` cells and holds each one until both source operands are available. Operands arrive from the common data bus (CDB) by tag match. Ready cells are issued one at a time, through a registered valid/ready port, to the execute stage.

## Interface
Parameters:
- `NUM_ENTRIES`, default 4: number of station entries (≥2).
- `TAG_BASE`, default 1: tag of entry 0. Entry *i* has tag `TAG_BASE+i`. Tag 0 means "operand ready" and is never allocated.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `dispatch_valid_in` in 1: dispatch request.
- `dispatch_op_in` in `res_st_cell_t`: incoming cell (`op`, `qj`, `qk`, `vj`, `vk`, `a`). The `busy` field is ignored.
- `dispatch_ready_out` out 1: a free entry exists and `flush_in` is low.
- `dispatch_tag_out` out `RS_TAG_W`: tag assigned to the cell accepted this cycle.
- `cdb_valid_in` in 1: CDB broadcast valid.
- `cdb_tag_in` in `RS_TAG_W`: producing tag.
- `cdb_value_in` in 32: broadcast result.
- `issue_valid_out` out 1: `issue_op_out` holds a ready cell.
- `issue_ready_in` in 1: the execute stage accepts the cell.
- `issue_op_out` out `res_st_cell_t`: issued cell. `busy` = 1 and `qj` = `qk` = 0 whenever valid.
- `free_count_out` out `$clog2(NUM_ENTRIES+1)`: number of free entries.
- `flush_in` in 1: synchronous squash of all contents.

## Operation
- **Dispatch.** A dispatch happens when `dispatch_valid_in && dispatch_ready_out`. The cell is written into the lowest-index free entry and that entry's busy bit is set. `dispatch_tag_out` = `TAG_BASE` + that index. It is combinational and meaningful only while `dispatch_ready_out` = 1.
- **Same-cycle forwarding at dispatch.** If `cdb_valid_in` is high and the incoming `qj` (or `qk`) is nonzero and equals `cdb_tag_in`, the entry stores `vj` (or `vk`) = `cdb_value_in` and `qj` (or `qk`) = 0.
- **Wakeup.** Every cycle, each busy entry whose `qj` (or `qk`) is nonzero and equals `cdb_tag_in`, with `cdb_valid_in` high, captures `cdb_value_in` into `vj` (or `vk`) and clears the tag. Both operands may wake in the same cycle.
- **Ready and select.** An entry is ready when it is busy and `qj == 0 && qk == 0`, evaluated on registered state. The default select is the lowest-index ready entry.
- **Issue register.**
  - When `!issue_valid_out || issue_ready_in`, the selected entry is copied into `issue_op_out` and its busy bit is cleared.
  - If no entry is ready at that point, `issue_valid_out` drops to 0.
  - While `issue_valid_out && !issue_ready_in`, `issue_op_out` is held bit-stable.
- **Entry reuse.** An entry freed by issue this cycle is not reusable by dispatch until the next cycle, because the free-entry search uses registered busy bits.
- **Flush.** On `flush_in` = 1, at the next edge all busy bits clear and `issue_valid_out` is cleared. Dispatch and CDB inputs are ignored in the flush cycle.
- **Reset values.**
  - All busy bits 0; `issue_valid_out` 0; `issue_op_out` all zero.
  - `dispatch_ready_out` 1; `dispatch_tag_out` `TAG_BASE`; `free_count_out` `NUM_ENTRIES`.
- **Reset mid-operation.** All held cells are discarded immediately, without waiting for a clock edge.

## Timing
- **Latency.** A cell with ready operands accepted at edge k appears with `issue_valid_out` = 1 after edge k+1, assuming the issue register is free. Zero-cycle dispatch-to-issue bypass is not provided.
- **Wakeup to issue.** A CDB broadcast at edge k makes its waiting entry ready after edge k; the cell is issued at edge k+1.
- **Throughput.** One dispatch and one issue per cycle.
- **`free_count_out`** is registered. It changes by +1 per issue and by −1 per dispatch, so the net change in a cycle is in the range −1..+1.
- **Full station.** When `free_count_out` = 0, `dispatch_ready_out` = 0. The stalled requester must hold its cell, and no state changes until an issue frees an entry.

## Configuration
- **`QU_RS_AGE_PRIORITY_EN` defined:**
  - Each entry carries a `$clog2(NUM_ENTRIES)`-bit age counter.
  - On dispatch, the new entry's age is set to 0 and every other busy entry's age increments.
  - Select picks the ready entry with the largest age (oldest first). Ties cannot occur.
- **`QU_RS_AGE_PRIORITY_EN` undefined:** no age state is kept; select is the lowest-index ready entry.

## Structure
- The `qu_common` package owns `RS_TAG_W` and `res_st_cell_t`. Its `qj`/`qk` fields are `RS_TAG_W` wide.
- `qu_res_station_select` is a sub-module: a combinational ready-vector to one-hot selector, with age-based and lowest-index variants selected by the macro.

## Test plan
1. **Ready cell passes through.** After reset, dispatch `op`=0, `vj`=5, `vk`=10, `qj`=`qk`=0 → `dispatch_tag_out`=1; one edge later `issue_valid_out`=1 with `vj`=5 and `vk`=10 unchanged.
2. **Wakeup from CDB.** Dispatch `op`=14'b01111000000000, `qj`=3, `vk`=10, `qk`=0; two cycles later broadcast CDB tag 3, value 20 → next edge the entry holds `vj`=20, `qj`=0; it issues the following edge with `vj`=20.
3. **Fill and stall.** Fill 4 entries, each waiting on tag 9 → `free_count_out`=0 and `dispatch_ready_out`=0; a 5th request is held and not accepted. Broadcast tag 9 → all four issue in order, entries 0 to 3.
4. **Backpressure.** Two ready cells with `issue_ready_in`=0 for 3 cycles → `issue_op_out` stays stable. Raise ready → the second cell appears on the next edge.
5. **Forward at dispatch.** Dispatch with `qj`=2 in the same cycle as CDB tag 2, value 7 → the entry stores `vj`=7, `qj`=0 and issues one edge later.
6. **Flush and reset mid-operation.** Flush with 3 entries busy and the issue register valid → after one edge, `free_count_out`=4 and `issue_valid_out`=0. Assert `rst_n` low mid-cycle → outputs return to their reset values immediately.

Source files
------------

// File: rtl/qu_common_pkg.sv
// Shared Qu core types: reservation-station tag width and the station cell layout.
package qu_common;

    localparam int RS_TAG_W = 5;
    localparam int RS_OP_W  = 14;

    typedef struct packed {
        logic                busy;
        logic [RS_OP_W-1:0]  op;
        logic [RS_TAG_W-1:0] qj;
        logic [RS_TAG_W-1:0] qk;
        logic [31:0]         vj;
        logic [31:0]         vk;
        logic [31:0]         a;
    } res_st_cell_t;

    // Tag 0 means "operand present", so it never matches a broadcast.
    function automatic logic tag_hit(
        input logic                valid,
        input logic [RS_TAG_W-1:0] q,
        input logic [RS_TAG_W-1:0] tag
    );
        return valid && (q != '0) && (q == tag);
    endfunction

endpackage

// File: rtl/qu_res_station_select.sv
// Issue selector: turns the ready vector into a one-hot grant.
// With QU_RS_AGE_PRIORITY_EN the oldest ready entry wins, otherwise the lowest index.
module qu_res_station_select #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic [NUM_ENTRIES-1:0]                          i_ready,
`ifdef QU_RS_AGE_PRIORITY_EN
    input  logic [NUM_ENTRIES-1:0][$clog2(NUM_ENTRIES)-1:0] i_age,
`endif
    output logic [NUM_ENTRIES-1:0]                          o_grant
);

`ifdef QU_RS_AGE_PRIORITY_EN
    localparam int AGE_W = $clog2(NUM_ENTRIES);

    logic [AGE_W-1:0] w_best_age;
    logic             w_found;

    always_comb begin
        o_grant    = '0;
        w_best_age = '0;
        w_found    = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (i_ready[i] && (!w_found || (i_age[i] > w_best_age))) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                w_best_age = i_age[i];
                w_found    = 1'b1;
            end
        end
    end
`else
    // Two's-complement trick isolates the lowest set bit.
    assign o_grant = i_ready & (~i_ready + NUM_ENTRIES'(1));
`endif

endmodule

// File: rtl/qu_res_station.sv
// Qu reservation station: holds dispatched cells until both operands arrive, issues one per cycle.
// Define QU_RS_AGE_PRIORITY_EN for oldest-first issue; the default build issues lowest index first.
module qu_res_station
    import qu_common::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_BASE    = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             dispatch_valid_in,
    input  res_st_cell_t                     dispatch_op_in,
    output logic                             dispatch_ready_out,
    output logic [RS_TAG_W-1:0]              dispatch_tag_out,
    input  logic                             cdb_valid_in,
    input  logic [RS_TAG_W-1:0]              cdb_tag_in,
    input  logic [31:0]                      cdb_value_in,
    output logic                             issue_valid_out,
    input  logic                             issue_ready_in,
    output res_st_cell_t                     issue_op_out,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] free_count_out,
    input  logic                             flush_in
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0] r_busy;
    res_st_cell_t           r_cell [NUM_ENTRIES];
    logic                   r_issue_valid;
    res_st_cell_t           r_issue_op;
    logic [CNT_W-1:0]       r_free_count;

    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_grant;
    logic [NUM_ENTRIES-1:0] w_free_onehot;
    logic [NUM_ENTRIES-1:0] w_wake_j;
    logic [NUM_ENTRIES-1:0] w_wake_k;
    logic [NUM_ENTRIES-1:0] w_busy_next;
    logic [IDX_W-1:0]       w_free_idx;
    logic                   w_has_free;
    logic                   w_any_ready;
    logic                   w_dispatch;
    logic                   w_issue_load;
    logic                   w_issue;
    res_st_cell_t           w_disp_cell;
    res_st_cell_t           w_issue_cell;

    // NOTE: every variable written in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_free_idx    = '0;
        w_free_onehot = '0;
        w_has_free    = 1'b0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx       = IDX_W'(i);
                w_free_onehot    = '0;
                w_free_onehot[i] = 1'b1;
                w_has_free       = 1'b1;
            end
        end
    end

    assign dispatch_ready_out = w_has_free && !flush_in;
    assign dispatch_tag_out   = RS_TAG_W'(TAG_BASE) + RS_TAG_W'(w_free_idx);
    assign w_dispatch         = dispatch_valid_in && dispatch_ready_out;

    always_comb begin
        w_ready  = '0;
        w_wake_j = '0;
        w_wake_k = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_ready[i]  = r_busy[i] && (r_cell[i].qj == '0) && (r_cell[i].qk == '0);
            w_wake_j[i] = !flush_in && r_busy[i] && tag_hit(cdb_valid_in, r_cell[i].qj, cdb_tag_in);
            w_wake_k[i] = !flush_in && r_busy[i] && tag_hit(cdb_valid_in, r_cell[i].qk, cdb_tag_in);
        end
    end

    // A broadcast in the dispatch cycle is captured directly into the new entry.
    always_comb begin
        w_disp_cell      = dispatch_op_in;
        w_disp_cell.busy = 1'b1;
        if (tag_hit(cdb_valid_in, dispatch_op_in.qj, cdb_tag_in)) begin
            w_disp_cell.vj = cdb_value_in;
            w_disp_cell.qj = '0;
        end
        if (tag_hit(cdb_valid_in, dispatch_op_in.qk, cdb_tag_in)) begin
            w_disp_cell.vk = cdb_value_in;
            w_disp_cell.qk = '0;
        end
    end

`ifdef QU_RS_AGE_PRIORITY_EN
    logic [IDX_W-1:0]                  r_age [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0][IDX_W-1:0] w_age_vec;
    logic [IDX_W-1:0]                  w_sel_age;

    always_comb begin
        w_age_vec = '0;
        w_sel_age = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_age_vec[i] = r_age[i];
            if (w_grant[i]) w_sel_age = r_age[i];
        end
    end

    // Age counts younger busy entries; decrementing past an issued entry keeps it dense and wrap-free.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_dispatch && w_free_onehot[i]) begin
                r_age[i] <= '0;
            end else if (r_busy[i]) begin
                r_age[i] <= r_age[i] + IDX_W'(w_dispatch)
                                     - IDX_W'(w_issue && (r_age[i] > w_sel_age));
            end
        end
    end
`endif

    qu_res_station_select #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_select (
        .i_ready (w_ready),
`ifdef QU_RS_AGE_PRIORITY_EN
        .i_age   (w_age_vec),
`endif
        .o_grant (w_grant)
    );

    always_comb begin
        w_issue_cell = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_grant[i]) w_issue_cell = r_cell[i];
        end
        w_issue_cell.busy = 1'b1;
        w_issue_cell.qj   = '0;
        w_issue_cell.qk   = '0;
    end

    assign w_any_ready  = |w_ready;
    assign w_issue_load = !r_issue_valid || issue_ready_in;
    assign w_issue      = w_issue_load && w_any_ready && !flush_in;
    assign w_busy_next  = (r_busy & ~(w_grant & {NUM_ENTRIES{w_issue}}))
                        | (w_free_onehot & {NUM_ENTRIES{w_dispatch}});

    // NOTE: entry payload carries no reset; the busy bits alone decide whether an entry holds anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_dispatch && w_free_onehot[i]) begin
                r_cell[i] <= w_disp_cell;
            end else begin
                if (w_wake_j[i]) begin
                    r_cell[i].vj <= cdb_value_in;
                    r_cell[i].qj <= '0;
                end
                if (w_wake_k[i]) begin
                    r_cell[i].vk <= cdb_value_in;
                    r_cell[i].qk <= '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= '0;
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_free_count  <= CNT_W'(NUM_ENTRIES);
        end else if (flush_in) begin
            r_busy        <= '0;
            r_issue_valid <= 1'b0;
            r_free_count  <= CNT_W'(NUM_ENTRIES);
        end else begin
            if (w_issue_load) begin
                r_issue_valid <= w_any_ready;
                if (w_any_ready) r_issue_op <= w_issue_cell;
            end
            r_busy       <= w_busy_next;
            r_free_count <= r_free_count + CNT_W'(w_issue) - CNT_W'(w_dispatch);
        end
    end

    assign issue_valid_out = r_issue_valid;
    assign issue_op_out    = r_issue_op;
    assign free_count_out  = r_free_count;

endmodule
